cond_unit: RTL and testbench

- Consumer end of the ALU status interface.
- Captures the N, Z, C, V flags the ALU produces into an architectural flag register.
- Evaluates each instruction's 4-bit ARM condition field against the registered flags, and gates the PC-source, register-write and memory-write enables of the single-cycle ARMv4 datapath.
- Keeps saturating executed/skipped instruction counters for debug.

---
 rtl/cond_pkg.sv | 17 +
 rtl/cond_check.sv | 39 +++
 rtl/cond_unit.sv | 84 ++++++++
 tb/tb_cond_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the ARM condition unit:
// condition codes and flag bit positions in {N,Z,C,V}.
package cond_pkg;

    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } cond_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field
// against a {N,Z,C,V} flag vector.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags[FLG_N];
    assign w_z = flags[FLG_Z];
    assign w_c = flags[FLG_C];
    assign w_v = flags[FLG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            C_EQ: cond_ex = w_z;
            C_NE: cond_ex = !w_z;
            C_CS: cond_ex = w_c;
            C_CC: cond_ex = !w_c;
            C_MI: cond_ex = w_n;
            C_PL: cond_ex = !w_n;
            C_VS: cond_ex = w_v;
            C_VC: cond_ex = !w_v;
            C_HI: cond_ex = w_c && !w_z;
            C_LS: cond_ex = !w_c || w_z;
            C_GE: cond_ex = (w_n == w_v);
            C_LT: cond_ex = (w_n != w_v);
            C_GT: cond_ex = !w_z && (w_n == w_v);
            C_LE: cond_ex = w_z || (w_n != w_v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Architectural flag register, condition gating of datapath
// write enables, and saturating executed/skipped counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pc_s,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec;
    logic [CNT_W-1:0] r_skip;
    logic             w_ex;
    logic             w_ok;
    logic             w_upd;

    cond_check u_check (
        .cond    (cond),
        .flags   (r_flags),
        .cond_ex (w_ex)
    );

    assign w_ok  = valid_in && !flush && w_ex;
    assign w_upd = valid_in && !stall;

    assign cond_ex   = w_ex;
    assign pc_src    = w_ok && pc_s;
    assign mem_write = w_ok && mem_w;
    assign reg_write = w_ok && reg_w && !no_write;
    assign flags_q   = r_flags;
    assign exec_cnt  = r_exec;
    assign skip_cnt  = r_skip;

    // Only a passing, unstalled instruction may touch the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_ok && !stall) begin
            if (flag_w[1]) begin
                r_flags[FLG_N] <= alu_flags[FLG_N];
                r_flags[FLG_Z] <= alu_flags[FLG_Z];
            end
            if (flag_w[0]) begin
                r_flags[FLG_C] <= alu_flags[FLG_C];
                r_flags[FLG_V] <= alu_flags[FLG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec <= '0;
            r_skip <= '0;
        end else if (w_upd) begin
            if (w_ok) begin
                if (r_exec != '1)
                    r_exec <= r_exec + 1'b1;
            end else begin
                if (r_skip != '1)
                    r_skip <= r_skip + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit with a behavioural
// reference model of flags, gating and counters.
module tb_cond_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in, stall, flush;
    logic [3:0]   cond, alu_flags;
    logic [1:0]   flag_w;
    logic         pc_s, reg_w, mem_w, no_write;
    logic         pc_src, reg_write, mem_write, cond_ex;
    logic [3:0]   flags_q;
    logic [W-1:0] exec_cnt, skip_cnt;

    int vec  = 0;
    int errs = 0;

    bit           m_n, m_z, m_c, m_v;
    logic [W-1:0] m_exec, m_skip;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .stall(stall), .flush(flush), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pc_s(pc_s),
        .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .cond_ex(cond_ex),
        .flags_q(flags_q), .exec_cnt(exec_cnt),
        .skip_cnt(skip_cnt)
    );

    // Predicate chosen by cond[3:1]; odd codes are the inverse
    function automatic bit ref_cond(input logic [3:0] cd);
        bit p;
        case (cd[3:1])
            3'd0: p = m_z;
            3'd1: p = m_c;
            3'd2: p = m_n;
            3'd3: p = m_v;
            3'd4: p = m_c && !m_z;
            3'd5: p = (m_n == m_v);
            3'd6: p = !m_z && (m_n == m_v);
            default: p = 1'b1;
        endcase
        if (cd[3:1] != 3'd7 && cd[0]) p = !p;
        return p;
    endfunction

    function automatic bit ref_ok();
        return valid_in && !flush && ref_cond(cond);
    endfunction

    function automatic logic [3:0] ref_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    task automatic model_reset();
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_exec = '0;
        m_skip = '0;
    endtask

    task automatic model_step();
        bit ok;
        ok = ref_ok();
        if (valid_in && !stall) begin
            if (ok) begin
                if (m_exec != '1) m_exec = m_exec + 1'b1;
            end else begin
                if (m_skip != '1) m_skip = m_skip + 1'b1;
            end
        end
        if (ok && !stall) begin
            if (flag_w[1]) {m_n, m_z} = alu_flags[3:2];
            if (flag_w[0]) {m_c, m_v} = alu_flags[1:0];
        end
    endtask

    task automatic drive(input logic v, st, fl,
                         input logic [3:0] cd, af,
                         input logic [1:0] fw,
                         input logic ps, rw, mw, nw);
        valid_in = v;  stall = st;  flush = fl;
        cond = cd;  alu_flags = af;  flag_w = fw;
        pc_s = ps;  reg_w = rw;  mem_w = mw;  no_write = nw;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(1, 0, 0, 4'hE, f, 2'b11, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        model_reset();
        #10;
        vec++;
        if (flags_q !== 4'b0000 || exec_cnt !== '0 || skip_cnt !== '0) begin
            errs++;
            $display("FAIL reset: flags=%b exec=%0d skip=%0d want 0000/0/0",
                     flags_q, exec_cnt, skip_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_eq_fail();
        drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
        vec++;
        if (cond_ex !== 1'b0 || reg_write !== 1'b0) begin
            errs++;
            $display("FAIL eq_fail: cond_ex=%b reg_write=%b want 0/0",
                     cond_ex, reg_write);
        end
        tick();
        vec++;
        if (skip_cnt !== 4'd1 || flags_q !== 4'b0000) begin
            errs++;
            $display("FAIL eq_fail_state: skip=%0d flags=%b want 1/0000",
                     skip_cnt, flags_q);
        end
    endtask

    task automatic test_cmp();
        drive(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
        vec++;
        if (reg_write !== 1'b0 || cond_ex !== 1'b1) begin
            errs++;
            $display("FAIL cmp: reg_write=%b cond_ex=%b want 0/1",
                     reg_write, cond_ex);
        end
        tick();
        vec++;
        if (flags_q !== 4'b0100 || exec_cnt !== 4'd1) begin
            errs++;
            $display("FAIL cmp_state: flags=%b exec=%0d want 0100/1",
                     flags_q, exec_cnt);
        end
        drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        vec++;
        if (pc_src !== 1'b1) begin
            errs++;
            $display("FAIL beq: pc_src=%b want 1", pc_src);
        end
        tick();
    endtask

    task automatic test_signed();
        logic [3:0] cds [4];
        bit         exp [4];
        cds = '{4'hA, 4'hB, 4'hC, 4'hD};
        exp = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_flags(4'b1000);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, cds[i], 4'hF, 2'b11, 1, 1, 1, 0);
            vec++;
            if (cond_ex !== exp[i]) begin
                errs++;
                $display("FAIL signed_%h: cond_ex=%b want %b",
                         cds[i], cond_ex, exp[i]);
            end
            vec++;
            if ({pc_src, reg_write, mem_write} !== 3'b000) begin
                errs++;
                $display("FAIL bubble_en: en=%b want 000",
                         {pc_src, reg_write, mem_write});
            end
            tick();
        end
        vec++;
        if (flags_q !== 4'b1000 || exec_cnt !== m_exec || skip_cnt !== m_skip) begin
            errs++;
            $display("FAIL bubble_state: flags=%b exec=%0d skip=%0d want 1000/%0d/%0d",
                     flags_q, exec_cnt, skip_cnt, m_exec, m_skip);
        end
    endtask

    task automatic test_partial();
        set_flags(4'b1111);
        drive(1, 0, 0, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
        tick();
        vec++;
        if (flags_q !== 4'b0011) begin
            errs++;
            $display("FAIL partial: flags=%b want 0011", flags_q);
        end
    endtask

    task automatic test_fail_flags();
        set_flags(4'b0100);
        drive(1, 0, 0, 4'h1, 4'b1010, 2'b11, 0, 0, 1, 0);
        vec++;
        if (mem_write !== 1'b0 || cond_ex !== 1'b0) begin
            errs++;
            $display("FAIL ne_fail: mem_write=%b cond_ex=%b want 0/0",
                     mem_write, cond_ex);
        end
        tick();
        vec++;
        if (flags_q !== 4'b0100 || skip_cnt !== m_skip) begin
            errs++;
            $display("FAIL ne_state: flags=%b skip=%0d want 0100/%0d",
                     flags_q, skip_cnt, m_skip);
        end
    endtask

    task automatic test_stall_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
            vec++;
            if ({pc_src, reg_write, mem_write} !== 3'b000) begin
                errs++;
                $display("FAIL stflush_en: en=%b want 000",
                         {pc_src, reg_write, mem_write});
            end
            tick();
        end
        vec++;
        if (flags_q !== 4'b0100 || exec_cnt !== m_exec || skip_cnt !== m_skip) begin
            errs++;
            $display("FAIL stflush_state: flags=%b exec=%0d skip=%0d want 0100/%0d/%0d",
                     flags_q, exec_cnt, skip_cnt, m_exec, m_skip);
        end
        drive(1, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        tick();
        vec++;
        if (flags_q !== 4'b0100 || skip_cnt !== m_skip) begin
            errs++;
            $display("FAIL flush: flags=%b skip=%0d want 0100/%0d",
                     flags_q, skip_cnt, m_skip);
        end
    endtask

    task automatic test_random();
        logic [3:0] f;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
                  $urandom_range(7, 0) == 0, 4'($urandom), 4'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            vec++;
            if (cond_ex !== ref_cond(cond)) begin
                errs++;
                $display("FAIL rnd_cond[%0d]: cond=%h cond_ex=%b want %b",
                         i, cond, cond_ex, ref_cond(cond));
            end
            vec++;
            if (pc_src !== (ref_ok() && pc_s) ||
                mem_write !== (ref_ok() && mem_w) ||
                reg_write !== (ref_ok() && reg_w && !no_write)) begin
                errs++;
                $display("FAIL rnd_en[%0d]: pc=%b rw=%b mw=%b ok=%b",
                         i, pc_src, reg_write, mem_write, ref_ok());
            end
            tick();
            f = ref_flags();
            vec++;
            if (flags_q !== f || exec_cnt !== m_exec || skip_cnt !== m_skip) begin
                errs++;
                $display("FAIL rnd_state[%0d]: flags=%b exec=%0d skip=%0d want %b/%0d/%0d",
                         i, flags_q, exec_cnt, skip_cnt, f, m_exec, m_skip);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
            tick();
        end
        vec++;
        if (exec_cnt !== 4'd15) begin
            errs++;
            $display("FAIL exec_sat: exec=%0d want 15", exec_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
            tick();
        end
        vec++;
        if (skip_cnt !== 4'd15) begin
            errs++;
            $display("FAIL skip_sat: skip=%0d want 15", skip_cnt);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        vec++;
        if (exec_cnt !== '0 || skip_cnt !== '0 || flags_q !== 4'b0000) begin
            errs++;
            $display("FAIL async_rst: exec=%0d skip=%0d flags=%b want 0/0/0000",
                     exec_cnt, skip_cnt, flags_q);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_eq_fail();
        test_cmp();
        test_signed();
        test_partial();
        test_fail_flags();
        test_stall_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
